fp_mul_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one mantissa multiplier (frac1 x frac2 -> R) among NREQ requesters.

---
 rtl/fp_mul_arbiter_pkg.sv | 15 +
 rtl/fp_mul_arbiter_if.sv | 26 ++
 rtl/fp_mul_arbiter_rr.sv | 32 +++
 rtl/fp_mul_arbiter.sv | 100 ++++++++++
 tb/tb_fp_mul_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mul_arbiter_pkg.sv
// Shared FPU types for the multiplier arbiter: fraction/product widths and sequencer states.
package fpu_pkg;

   localparam int N = 24;

   typedef logic [N-2:0]   frac_t;
   typedef logic [2*N-2:0] prod_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } mul_arb_state_e;

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Requester-side bundle of the shared multiplier: operand request channel and product response channel.
interface fp_mul_arbiter_if #(
   parameter int N    = fpu_pkg::N,
   parameter int NREQ = 2
);
   // valid/ready: a transfer on lane i happens on the rising clk edge where valid[i] & ready[i];
   // valid never waits for ready, and ready/valid vectors are at most one-hot.
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*(N-1)-1:0] req_frac1;
   logic [NREQ*(N-1)-1:0] req_frac2;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [2*N-2:0]        rsp_prod;

   modport master (
      output req_valid, req_frac1, req_frac2, rsp_ready,
      input  req_ready, rsp_valid, rsp_prod
   );

   modport slave (
      input  req_valid, req_frac1, req_frac2, rsp_ready,
      output req_ready, rsp_valid, rsp_prod
   );

endinterface

// File: rtl/fp_mul_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping, as one-hot and index.
module rr_arbiter #(
   parameter  int NREQ = 2,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx
);

   int              idx;
   logic [NREQ-1:0] mask;

   // Walk offsets from farthest to nearest so the closest requester to ptr wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      idx     = 0;
      mask    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         mask = NREQ'(1) << idx;
         if (|(req & mask)) begin
            gnt     = mask;
            gnt_idx = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin sequencer sharing one mantissa multiplier: accept one operand pair, hold it for MUL_LAT
// cycles, capture the product and return it to the granted requester.
module fp_mul_arbiter
   import fpu_pkg::*;
#(
   parameter  int N       = fpu_pkg::N,
   parameter  int NREQ    = 2,
   parameter  int MUL_LAT = 2,
   localparam int IW      = $clog2(NREQ)
) (
   input  logic           clk,
   input  logic           rst,
   fp_mul_arbiter_if.slave bus,
   output logic [N-2:0]   mul_frac1,
   output logic [N-2:0]   mul_frac2,
   input  logic [2*N-2:0] mul_R,
   output logic           busy,
   output mul_arb_state_e dbg_state
);

   mul_arb_state_e  state, state_nxt;
   logic [IW-1:0]   rr_ptr, gnt_q, arb_idx;
   logic [NREQ-1:0] arb_gnt;
   logic [3:0]      cnt;
   logic [N-2:0]    op1_q, op2_q;
   logic [2*N-2:0]  prod_q;
   logic            req_hs, rsp_hs;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req     (bus.req_valid),
      .ptr     (rr_ptr),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.req_ready = '0;
      bus.rsp_valid = '0;
      req_hs        = 1'b0;
      rsp_hs        = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = arb_gnt;
            req_hs        = |arb_gnt;
            if (req_hs) state_nxt = BUSY;
         end
         BUSY: begin
            if (cnt == '0) state_nxt = RESP;
         end
         RESP: begin
            bus.rsp_valid = NREQ'(1) << gnt_q;
            rsp_hs        = |(bus.rsp_valid & bus.rsp_ready);
            if (rsp_hs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operands are captured only on the accept edge, so later input changes never reach the multiplier.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
         gnt_q  <= '0;
         cnt    <= '0;
         op1_q  <= '0;
         op2_q  <= '0;
         prod_q <= '0;
      end else begin
         if (req_hs) begin
            op1_q  <= bus.req_frac1[arb_idx*(N-1) +: N-1];
            op2_q  <= bus.req_frac2[arb_idx*(N-1) +: N-1];
            gnt_q  <= arb_idx;
            rr_ptr <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            cnt    <= 4'(MUL_LAT - 1);
         end
         if (state == BUSY) begin
            if (cnt == '0) prod_q <= mul_R;
            else           cnt    <= cnt - 1'b1;
         end
      end
   end

   assign mul_frac1    = op1_q;
   assign mul_frac2    = op2_q;
   assign bus.rsp_prod = prod_q;
   assign busy         = (state != IDLE);
   assign dbg_state    = state;

   a_req_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
   a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.rsp_valid));
   a_rsp_prod_stable:  assert property (@(posedge clk) disable iff (rst)
      (|bus.rsp_valid && !(|(bus.rsp_valid & bus.rsp_ready))) |=> $stable(bus.rsp_prod));

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: directed scenarios plus a random soak against a product/round-robin model.
`timescale 1ns/1ps
module tb_fp_mul_arbiter;
   import fpu_pkg::*;

   localparam int NREQ    = 2;
   localparam int MUL_LAT = 2;
   localparam int IW      = $clog2(NREQ);
   localparam int FW      = N - 1;
   localparam int PW      = 2 * N - 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fp_mul_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

   logic [FW-1:0]  mul_frac1, mul_frac2;
   logic [PW-1:0]  mul_R;
   logic           busy;
   mul_arb_state_e dbg_state;

   // Behavioural stand-in for the shared multiplier.
   assign mul_R = PW'(mul_frac1) * PW'(mul_frac2);

   fp_mul_arbiter #(.N(N), .NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .mul_frac1 (mul_frac1),
      .mul_frac2 (mul_frac2),
      .mul_R     (mul_R),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- driver state ----------------
   logic [NREQ-1:0] v, rr;
   logic [FW-1:0]   a [NREQ];
   logic [FW-1:0]   b [NREQ];
   bit              soak;
   int              hold;

   assign bus.req_valid = v;
   assign bus.req_frac1 = {a[1], a[0]};
   assign bus.req_frac2 = {b[1], b[0]};
   assign bus.rsp_ready = rr;

   logic [FW-1:0] sa0[$], sb0[$], sa1[$], sb1[$];
   logic [PW-1:0] exp_q0[$], exp_q1[$];
   int            glog[$];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_stim(input logic [IW-1:0] i, input logic [FW-1:0] x, input logic [FW-1:0] y);
      if (i == 1'b0) begin sa0.push_back(x); sb0.push_back(y); end
      else           begin sa1.push_back(x); sb1.push_back(y); end
   endtask

   task automatic requeue(input logic [IW-1:0] i, input logic [FW-1:0] x, input logic [FW-1:0] y);
      if (i == 1'b0) begin sa0.push_front(x); sb0.push_front(y); end
      else           begin sa1.push_front(x); sb1.push_front(y); end
   endtask

   task automatic pop_stim(input logic [IW-1:0] i, output bit have, output logic [FW-1:0] x,
                           output logic [FW-1:0] y);
      have = 1'b0; x = '0; y = '0;
      if (i == 1'b0) begin
         if (sa0.size() > 0) begin have = 1'b1; x = sa0.pop_front(); y = sb0.pop_front(); end
      end else begin
         if (sa1.size() > 0) begin have = 1'b1; x = sa1.pop_front(); y = sb1.pop_front(); end
      end
   endtask

   task automatic drive_one(input logic [IW-1:0] i, input logic acc);
      logic [FW-1:0] na, nb;
      bit            have;
      if (acc) begin
         // after acceptance the operand lines carry junk; the product must not care
         v[i] = 1'b0; a[i] = FW'($urandom); b[i] = FW'($urandom);
      end else if (v[i] && soak && $urandom_range(0, 7) == 0) begin
         v[i] = 1'b0; requeue(i, a[i], b[i]);
      end
      if (!v[i] && (!soak || $urandom_range(0, 2) != 0)) begin
         pop_stim(i, have, na, nb);
         if (have) begin v[i] = 1'b1; a[i] = na; b[i] = nb; end
      end
   endtask

   // One clock: note accepts (and their expected products) before the edge, then drive after it.
   task automatic step();
      logic [NREQ-1:0] acc;
      @(negedge clk);
      acc = v & bus.req_ready;
      if (acc[0]) exp_q0.push_back(PW'(a[0]) * PW'(b[0]));
      if (acc[1]) exp_q1.push_back(PW'(a[1]) * PW'(b[1]));
      @(posedge clk);
      #1;
      drive_one(1'b0, acc[0]);
      drive_one(1'b1, acc[1]);
      if (hold > 0) begin rr = '0; hold--; end
      else if (soak) rr = NREQ'($urandom_range(0, 3));
      else rr = '1;
   endtask

   task automatic run(input int max_cyc, input string name);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (n < max_cyc && !(sa0.size() == 0 && sa1.size() == 0 && v == '0 &&
                 exp_q0.size() == 0 && exp_q1.size() == 0 && !busy));
      chk({"drain_", name}, 64'(n < max_cyc), 64'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1; v = '0; rr = '1; hold = 0;
      a[0] = '0; a[1] = '0; b[0] = '0; b[1] = '0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      glog.delete(); exp_q0.delete(); exp_q1.delete();
      sa0.delete(); sb0.delete(); sa1.delete(); sb1.delete();
   endtask

   // ---------------- monitor / scoreboard ----------------
   bit            outst;
   logic [IW-1:0] owner;
   int            acc_cyc, rr_next, j;
   logic [FW-1:0] acc_a, acc_b;
   logic [NREQ-1:0] exp_rdy, exp_vld, hs;
   logic [PW-1:0] e;

   initial begin
      outst = 1'b0; owner = '0; acc_cyc = 0; rr_next = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            outst = 1'b0; rr_next = 0;
            chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
            chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            chk("rst_rsp_prod",  64'(bus.rsp_prod),  64'd0);
            chk("rst_mul_frac1", 64'(mul_frac1), 64'd0);
            chk("rst_mul_frac2", 64'(mul_frac2), 64'd0);
            chk("rst_busy",      64'(busy), 64'd0);
            chk("rst_state",     64'(dbg_state), 64'(IDLE));
         end else begin
            // grant rule: free arbiter offers the first valid requester at/after the rotating pointer
            exp_rdy = '0;
            if (!outst)
               for (int k = 0; k < NREQ; k++) begin
                  j = (rr_next + k) % NREQ;
                  if (exp_rdy == '0 && |(bus.req_valid & (NREQ'(1) << j))) exp_rdy = NREQ'(1) << j;
               end
            exp_vld = (outst && (cyc - acc_cyc) >= MUL_LAT + 1) ? (NREQ'(1) << owner) : '0;
            chk("busy",      64'(busy), 64'(outst));
            chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_vld));
            chk("state", 64'(dbg_state),
                64'(!outst ? IDLE : (exp_vld != '0 ? RESP : BUSY)));
            if (outst) begin
               chk("mul_frac1_hold", 64'(mul_frac1), 64'(acc_a));
               chk("mul_frac2_hold", 64'(mul_frac2), 64'(acc_b));
            end
            if (exp_vld != '0) begin
               chk("sb_depth", 64'(owner == 1'b0 ? exp_q0.size() : exp_q1.size()), 64'd1);
               if ((owner == 1'b0 ? exp_q0.size() : exp_q1.size()) > 0) begin
                  e = (owner == 1'b0) ? exp_q0[0] : exp_q1[0];
                  chk("rsp_prod", 64'(bus.rsp_prod), 64'(e));
                  if (|(bus.rsp_ready & (NREQ'(1) << owner))) begin
                     if (owner == 1'b0) void'(exp_q0.pop_front());
                     else               void'(exp_q1.pop_front());
                     outst = 1'b0;
                  end
               end
            end
            hs = bus.req_valid & bus.req_ready;
            if (hs != '0) begin
               owner   = hs[0] ? 1'b0 : 1'b1;
               acc_cyc = cyc;
               acc_a   = a[owner];
               acc_b   = b[owner];
               outst   = 1'b1;
               rr_next = (int'(owner) + 1) % NREQ;
               glog.push_back(int'(owner));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      soak = 1'b0; hold = 0; rst = 1'b1; v = '0; rr = '1;
      a[0] = '0; a[1] = '0; b[0] = '0; b[1] = '0;

      // single request, immediate response acceptance
      do_reset();
      push_stim(1'b0, 23'd7, 23'd3);
      run(40, "single");
      chk("t1_grants", 64'(glog.size()), 64'd1);

      // contention from reset: alternate 0,1,0,1
      do_reset();
      push_stim(1'b0, 23'd7, 23'd3);        push_stim(1'b1, 23'h400000, 23'd2);
      push_stim(1'b0, 23'd7, 23'd3);        push_stim(1'b1, 23'h400000, 23'd2);
      run(80, "contention");
      chk("t2_grants", 64'(glog.size()), 64'd4);
      for (int k = 0; k < 4 && k < glog.size(); k++)
         chk("t2_order", 64'(glog[k]), 64'(k % 2));

      // response backpressure while product is pending
      glog.delete();
      hold = 10;
      push_stim(1'b0, 23'd7, 23'd3);
      run(60, "backpressure");

      // operand lines change after acceptance
      push_stim(1'b0, 23'd7, 23'd3);
      glog.delete();
      n = 0;
      while (glog.size() == 0 && n < 20) begin step(); n++; end
      a[0] = 23'd9;
      run(40, "operand_change");

      // extreme operands
      push_stim(1'b0, 23'h7FFFFF, 23'h7FFFFF);
      push_stim(1'b1, 23'h7FFFFF, 23'd0);
      run(60, "max_ops");

      // reset while BUSY aborts silently and the pointer returns to requester 0
      do_reset();
      push_stim(1'b0, 23'd7, 23'd3);
      n = 0;
      while (glog.size() == 0 && n < 20) begin step(); n++; end
      chk("t5_accept", 64'(glog.size()), 64'd1);
      step();
      rst = 1'b1;
      exp_q0.delete(); exp_q1.delete();
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      glog.delete();
      push_stim(1'b0, 23'd5, 23'd6);
      push_stim(1'b1, 23'd9, 23'd10);
      run(60, "after_abort");
      chk("t5_grants", 64'(glog.size()), 64'd2);
      if (glog.size() > 0) chk("t5_first_grant", 64'(glog[0]), 64'd0);

      // random soak
      soak = 1'b1;
      for (int k = 0; k < 500; k++) begin
         push_stim(1'b0, ($urandom_range(0, 5) == 0) ? 23'h7FFFFF : FW'($urandom),
                         ($urandom_range(0, 5) == 0) ? 23'h7FFFFF : FW'($urandom));
         push_stim(1'b1, ($urandom_range(0, 5) == 0) ? 23'd0 : FW'($urandom),
                         FW'($urandom));
      end
      run(40000, "soak");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
